// File: rtl/fp_normalize32.sv
// FP32 normalization stage: aligns the leading bit, adjusts the exponent, shifts denormals in
// and folds low-order bits into guard/sticky for the downstream rounder. Three ce-gated stages.
module fp_normalize32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        vld_i,
  input  logic        sign_i,
  input  logic [9:0]  exp_i,
  input  logic [47:0] sig_i,
  input  logic        inf_i,
  input  logic        nan_i,
  output logic        vld_o,
  output logic [34:0] o,
  output logic        over_o,
  output logic        under_o
);

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_NAN,
    SEL_INF,
    SEL_OVER,
    SEL_UNDER,
    SEL_NORM
  } sel_t;

  function automatic logic [5:0] clz48(input logic [47:0] v);
    clz48 = 6'd48;
    for (int i = 0; i < 48; i++)
      if (v[i]) clz48 = 6'(47 - i);
  endfunction

  // stage 1
  logic        s1_vld, s1_sign, s1_inf, s1_nan;
  logic [9:0]  s1_exp;
  logic [47:0] s1_sig;
  logic [5:0]  s1_lz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_inf  <= 1'b0;
      s1_nan  <= 1'b0;
      s1_exp  <= '0;
      s1_sig  <= '0;
      s1_lz   <= '0;
    end else if (ce) begin
      s1_vld  <= vld_i;
      s1_sign <= sign_i;
      s1_inf  <= inf_i;
      s1_nan  <= nan_i;
      s1_exp  <= exp_i;
      s1_sig  <= sig_i;
      s1_lz   <= clz48(sig_i);
    end
  end

  // stage 2: exponent, shift amount/direction, case select
  logic signed [10:0] en_c, sh_c, sh_neg;
  logic [5:0]         amt_c;
  logic               right_c;
  sel_t               sel_c;

  always_comb begin
    en_c    = $signed({s1_exp[9], s1_exp}) + 11'sd1 - $signed({5'd0, s1_lz});
    sh_c    = (en_c >= 11'sd1) ? $signed({5'd0, s1_lz}) : $signed({s1_exp[9], s1_exp});
    sh_neg  = -sh_c;
    right_c = sh_c < 11'sd0;
    amt_c   = sh_c[5:0];
    if (right_c)
      amt_c = (sh_neg > 11'sd49) ? 6'd49 : sh_neg[5:0];
    sel_c = SEL_NORM;
    if (s1_nan)                  sel_c = SEL_NAN;
    else if (s1_inf)             sel_c = SEL_INF;
    else if (s1_lz == 6'd48)     sel_c = SEL_ZERO;
    else if (en_c >= 11'sd255)   sel_c = SEL_OVER;
    else if (en_c <= 11'sd0)     sel_c = SEL_UNDER;
  end

  logic        s2_vld, s2_sign, s2_right;
  logic [47:0] s2_sig;
  logic [7:0]  s2_efld;
  logic [5:0]  s2_amt;
  sel_t        s2_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld   <= 1'b0;
      s2_sign  <= 1'b0;
      s2_right <= 1'b0;
      s2_sig   <= '0;
      s2_efld  <= '0;
      s2_amt   <= '0;
      s2_sel   <= SEL_ZERO;
    end else if (ce) begin
      s2_vld   <= s1_vld;
      s2_sign  <= s1_sign;
      s2_right <= right_c;
      s2_sig   <= s1_sig;
      s2_efld  <= en_c[7:0];
      s2_amt   <= amt_c;
      s2_sel   <= sel_c;
    end
  end

  // stage 3: the low 49 bits of the window catch everything a right shift pushes out
  logic [96:0] wide_c;
  logic [47:0] s_c;
  logic        sticky_c;
  logic [34:0] o_c;
  logic        over_c, under_c;

  always_comb begin
    wide_c   = s2_right ? ({s2_sig, 49'd0} >> s2_amt) : {s2_sig << s2_amt, 49'd0};
    s_c      = wide_c[96:49];
    sticky_c = (|s_c[22:0]) | (|wide_c[48:0]);
    over_c   = 1'b0;
    under_c  = 1'b0;
    o_c      = {s2_sign, s2_efld, s_c[47:24], s_c[23], sticky_c};
    case (s2_sel)
      SEL_NAN:  o_c = {s2_sign, 8'hFF, 2'b11, 24'd0};
      SEL_INF:  o_c = {s2_sign, 8'hFF, 26'd0};
      SEL_ZERO: o_c = {s2_sign, 34'd0};
      SEL_OVER: begin
        o_c    = {s2_sign, 8'hFF, 26'd0};
        over_c = 1'b1;
      end
      SEL_UNDER: begin
        o_c     = {s2_sign, 8'h00, s_c[47:24], s_c[23], sticky_c};
        under_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_o   <= 1'b0;
      o       <= '0;
      over_o  <= 1'b0;
      under_o <= 1'b0;
    end else if (ce) begin
      vld_o   <= s2_vld;
      o       <= o_c;
      over_o  <= over_c;
      under_o <= under_c;
    end
  end

endmodule

// File: doc/fp_normalize32.md
# fp_normalize32

Single-precision normalization stage that sits directly upstream of the FP32 rounding stage. Accepts an unnormalized sign/exponent/48-bit significand from the multiplier or adder datapath and emits the FP32N intermediate word the rounder consumes: leading bit aligned, exponent adjusted, denormals shifted in, and low-order bits collapsed to guard/sticky. It is a 3-stage, clock-enable-qualified pipeline with a travelling valid bit and overflow/underflow flags.

## Interface
- No parameters; widths are fixed by fp32Pkg (EMSB=7, FMSB=22).
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; all pipeline registers, including valid, advance only when ce=1.
- vld_i  input  1  input word valid.
- sign_i  input  1  result sign.
- exp_i  input  10  two's-complement biased exponent, range -512..511.
- sig_i  input  48  significand; value = sig_i / 2^46, so range [0,4).
- inf_i  input  1  force infinity.
- nan_i  input  1  force canonical quiet NaN.
- vld_o  output  1  output valid.
- o  output  35  FP32N word: [34] sign, [33:26] exponent, [25] leading bit, [24:2] fraction, [1] guard, [0] sticky.
- over_o  output  1  exponent overflowed to infinity.
- under_o  output  1  result is tiny (exponent field 0, nonzero), before rounding.

## Operation
- lz = count of leading zeros of sig_i, 0..48.
- e_n = exp_i + 1 - lz, 11-bit signed. No wrap is permitted at any width.
- Shift amount: sh = lz when e_n >= 1; otherwise sh = lz + e_n - 1.
  - sh >= 0 is a left shift of sig_i.
  - sh < 0 is a right shift by -sh, clamped at 49. Every bit shifted out ORs into sticky.
- After the shift, the 48-bit value s is packed as follows:
  - o[25:2] = s[47:24]
  - o[1] = s[23]
  - o[0] = |s[22:0] | (bits lost to the right shift)
- Exponent field is e_n when 1 <= e_n <= 254, and 0 when e_n <= 0 (denormal; o[25] = 0).
- Priority, highest first:
  1. nan_i: exp 255, o[25:24] = 2'b11, rest 0, sign passes.
  2. inf_i: exp 255, significand 0.
  3. sig_i == 0: exp 0, significand 0, sign passes, flags 0.
  4. e_n >= 255: infinity, over_o = 1.
  5. e_n <= 0: denormal, under_o = 1.
  6. Otherwise normal.
- over_o and under_o are 0 for NaN, infinity and zero inputs.
- Pipeline stages:
  - S1 registers the inputs and lz.
  - S2 registers e_n, sh, the shift direction and the case select.
  - S3 performs the shift, sticky collapse and packing, then registers o and the flags.

## Timing
- Latency is exactly 3 ce-qualified clock edges from vld_i to vld_o. Throughput is one word per ce cycle; there is no backpressure.
- ce=0 holds every register, including vld_o, o and the flags, unchanged. Words never drop or duplicate across ce gaps.
- Data registers load whenever ce=1, regardless of vld. vld_o qualifies o.
- Reset (rst_n=0, asynchronous):
  - vld_o = 0, o = 35'h0, over_o = 0, under_o = 0.
  - All in-flight stage contents are cleared; words in flight at reset are discarded and never emerge.
- First valid output after reset release appears 3 ce edges after the first accepted vld_i.
- nan_i and inf_i take effect in S2 and S3 selection. Their sig_i contents are don't-care and must not affect the flags.

## Test plan
- 1.0 case: sig_i = 48'h4000_0000_0000, exp_i = 127, sign 0, vld_i for one ce cycle.
  -> vld_o on the 3rd edge; o = {1'b0, 8'd127, 26'h200_0000}; flags 0.
- Carry position: sig_i = 48'h8000_0000_0001, exp_i = 127.
  -> exp 128, o[25:0] = 26'h200_0000 with sticky o[0] = 1.
- Deep left shift: sig_i = 48'h0000_0000_0001, exp_i = 200.
  -> lz = 47, exp 154, o[25:0] = 26'h200_0000.
- Overflow: sig_i = 48'h4000_0000_0000, exp_i = 255.
  -> o = 35'h3_FC00_0000, over_o = 1.
- Denormal: sig_i = 48'h4000_0000_0000, exp_i = -2.
  -> o = {1'b0, 8'd0, 26'h040_0000}, under_o = 1.
- Denormal, full clamp: sig_i = 48'h4000_0000_0001, exp_i = -100.
  -> significand 0, o[0] = 1, under_o = 1.
- Pipeline control: three back-to-back words with ce toggling 1,0,1,1,0,1.
  -> outputs emerge in order, each exactly 3 ce edges after entry.
  -> Then assert rst_n = 0 with 2 words in flight: vld_o falls immediately, neither word appears after release.
  -> A NaN input with sig_i = 0 yields exp 255, o[25:24] = 2'b11, flags 0.
